// File: rtl/dmem_resp_pkg.sv
// Shared codes and widths for the data-memory responder: request size codes,
// responder FSM states and the bus widths used by the execute-stage interface.
package dmem_resp_pkg;

    localparam int ADDR_W      = 32;
    localparam int WORD_W      = 32;
    localparam int MEM_COUNT_W = 2;
    localparam int CNT_W       = 4;

    // Access size carried on i_req_count; anything but NONE is a request.
    localparam logic [MEM_COUNT_W-1:0] MEM_COUNT_NONE = 2'd0;
    localparam logic [MEM_COUNT_W-1:0] MEM_COUNT_BYTE = 2'd1;
    localparam logic [MEM_COUNT_W-1:0] MEM_COUNT_HALF = 2'd2;
    localparam logic [MEM_COUNT_W-1:0] MEM_COUNT_WORD = 2'd3;

    localparam int DMEM_STATE_W = 2;

    typedef enum logic [DMEM_STATE_W-1:0] {
        DMEM_STATE_IDLE = 2'd0,
        DMEM_STATE_BUSY = 2'd1,
        DMEM_STATE_DONE = 2'd2
    } dmem_state_t;

endpackage

// File: rtl/dmem_lane.sv
// Byte-lane steering for the data-memory responder: merges store data into the
// addressed lanes of the old word, extracts right-justified zero-extended load
// data, and flags accesses whose size does not match the address alignment.
module dmem_lane
    import dmem_resp_pkg::*;
(
    input  logic [1:0]             lane,
    input  logic [MEM_COUNT_W-1:0] count,
    input  logic [WORD_W-1:0]      old_word,
    input  logic [WORD_W-1:0]      wr_data,
    output logic [WORD_W-1:0]      merged,
    output logic [WORD_W-1:0]      rd_data,
    output logic                   misalign
);

    logic [4:0] byte_sh;
    logic [4:0] half_sh;

    assign byte_sh = {lane, 3'b000};
    assign half_sh = {lane[1], 4'b0000};

    // Lane merge/extract per access size (little-endian lanes).
    always_comb begin
        merged   = old_word;
        rd_data  = '0;
        misalign = 1'b0;
        case (count)
            MEM_COUNT_BYTE: begin
                merged  = (old_word & ~(32'h0000_00ff << byte_sh))
                        | ({24'b0, wr_data[7:0]} << byte_sh);
                rd_data = (old_word >> byte_sh) & 32'h0000_00ff;
            end
            MEM_COUNT_HALF: begin
                merged   = (old_word & ~(32'h0000_ffff << half_sh))
                         | ({16'b0, wr_data[15:0]} << half_sh);
                rd_data  = (old_word >> half_sh) & 32'h0000_ffff;
                misalign = lane[0];
            end
            MEM_COUNT_WORD: begin
                merged   = wr_data;
                rd_data  = old_word;
                misalign = |lane;
            end
            default: begin
                merged = old_word;
            end
        endcase
    end

endmodule

// File: rtl/dmem_resp.sv
// Data-memory responder: accepts one byte/half/word request from the execute
// stage, stalls the pipeline for LATENCY busy cycles, then performs the RAM
// access and pulses o_done (with o_fault on misaligned/out-of-range accesses).
module dmem_resp
    import dmem_resp_pkg::*;
#(
    parameter int LATENCY    = 2,
    parameter int DEPTH_LOG2 = 10
) (
    input  logic                   clk,
    input  logic                   clr,
    input  logic [ADDR_W-1:0]      i_req_addr,
    input  logic [WORD_W-1:0]      i_req_wr_data,
    input  logic                   i_req_wr_en,
    input  logic [MEM_COUNT_W-1:0] i_req_count,
    output logic                   o_stall,
    output logic                   o_done,
    output logic [WORD_W-1:0]      o_rd_data,
    output logic                   o_fault
);

    localparam int DEPTH = 1 << DEPTH_LOG2;

    dmem_state_t             state_q, state_d;
    logic [CNT_W-1:0]        cnt_q, cnt_d;
    logic [ADDR_W-1:0]       addr_q;
    logic [WORD_W-1:0]       data_q;
    logic                    wr_en_q;
    logic [MEM_COUNT_W-1:0]  count_q;

    logic [WORD_W-1:0]       ram [DEPTH];

    logic                    req_valid;
    logic                    finish;
    logic                    out_of_range;
    logic                    misalign;
    logic                    fault;
    logic [DEPTH_LOG2-1:0]   word_idx;
    logic [WORD_W-1:0]       old_word;
    logic [WORD_W-1:0]       merged;
    logic [WORD_W-1:0]       load_data;

    assign req_valid    = (i_req_count != MEM_COUNT_NONE);
    assign finish       = (state_q == DMEM_STATE_BUSY) && (cnt_q == '0);
    assign word_idx     = addr_q[DEPTH_LOG2+1:2];
    assign out_of_range = |(addr_q >> (DEPTH_LOG2 + 2));
    assign fault        = misalign | out_of_range;
    assign old_word     = ram[word_idx];

    dmem_lane u_lane (
        .lane     (addr_q[1:0]),
        .count    (count_q),
        .old_word (old_word),
        .wr_data  (data_q),
        .merged   (merged),
        .rd_data  (load_data),
        .misalign (misalign)
    );

    // Next state, busy counter and pipeline stall.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        o_stall = 1'b0;
        case (state_q)
            DMEM_STATE_IDLE: begin
                o_stall = req_valid;
                if (req_valid) begin
                    state_d = DMEM_STATE_BUSY;
                    cnt_d   = CNT_W'(LATENCY - 1);
                end
            end
            DMEM_STATE_BUSY: begin
                o_stall = 1'b1;
                if (cnt_q == '0) begin
                    state_d = DMEM_STATE_DONE;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            DMEM_STATE_DONE: begin
                state_d = DMEM_STATE_IDLE;
            end
            default: begin
                state_d = DMEM_STATE_IDLE;
            end
        endcase
    end

    // State, counter, latched request and registered completion outputs.
    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            state_q   <= DMEM_STATE_IDLE;
            cnt_q     <= '0;
            addr_q    <= '0;
            data_q    <= '0;
            wr_en_q   <= 1'b0;
            count_q   <= MEM_COUNT_NONE;
            o_done    <= 1'b0;
            o_fault   <= 1'b0;
            o_rd_data <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            o_done  <= 1'b0;
            o_fault <= 1'b0;
            if (state_q == DMEM_STATE_IDLE && req_valid) begin
                addr_q  <= i_req_addr;
                data_q  <= i_req_wr_data;
                wr_en_q <= i_req_wr_en;
                count_q <= i_req_count;
            end
            if (finish) begin
                o_done    <= 1'b1;
                o_fault   <= fault;
                o_rd_data <= (fault || wr_en_q) ? '0 : load_data;
            end
        end
    end

    // RAM write on the final busy edge; a reset beforehand leaves RAM untouched.
    always_ff @(posedge clk) begin
        if (finish && wr_en_q && !fault) begin
            ram[word_idx] <= merged;
        end
    end

endmodule

// File: tb/tb_dmem_resp.sv
// Directed bench for dmem_resp: a vector table of load/store requests with
// hand-computed results, plus hand sequences for reset and mid-access abort.
module tb_dmem_resp;
    import dmem_resp_pkg::*;

    localparam int LAT = 2;

    logic                   clk;
    logic                   clr;
    logic [ADDR_W-1:0]      i_req_addr;
    logic [WORD_W-1:0]      i_req_wr_data;
    logic                   i_req_wr_en;
    logic [MEM_COUNT_W-1:0] i_req_count;
    logic                   o_stall;
    logic                   o_done;
    logic [WORD_W-1:0]      o_rd_data;
    logic                   o_fault;

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic                   wr;
        logic [MEM_COUNT_W-1:0] cnt;
        logic [ADDR_W-1:0]      addr;
        logic [WORD_W-1:0]      data;
        logic                   exp_fault;
        logic [WORD_W-1:0]      exp_rd;
    } vec_t;

    localparam int NV = 19;
    vec_t vecs [NV];

    dmem_resp #(.LATENCY(LAT), .DEPTH_LOG2(10)) dut (
        .clk           (clk),
        .clr           (clr),
        .i_req_addr    (i_req_addr),
        .i_req_wr_data (i_req_wr_data),
        .i_req_wr_en   (i_req_wr_en),
        .i_req_count   (i_req_count),
        .o_stall       (o_stall),
        .o_done        (o_done),
        .o_rd_data     (o_rd_data),
        .o_fault       (o_fault)
    );

    // Clock generation.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    // Issue one request at posedge+1 and hold it through DONE, then drop to NONE.
    // Reports the cycle o_done was seen, the stall shape, results, and any extra
    // stall/done activity in the two idle cycles afterwards.
    task automatic run_req(input logic wr, input logic [MEM_COUNT_W-1:0] cnt,
                           input logic [ADDR_W-1:0] addr, input logic [WORD_W-1:0] data,
                           output int done_cyc, output bit stall_ok,
                           output logic f, output logic [WORD_W-1:0] rd, output int extra);
        i_req_wr_en   = wr;
        i_req_count   = cnt;
        i_req_addr    = addr;
        i_req_wr_data = data;
        done_cyc = -1;
        stall_ok = 1'b1;
        f        = 1'b0;
        rd       = '0;
        extra    = 0;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            if (o_done === 1'b1) begin
                done_cyc = c;
                f        = o_fault;
                rd       = o_rd_data;
                if (o_stall !== 1'b0) stall_ok = 1'b0;
            end else if (o_stall !== 1'b1) begin
                stall_ok = 1'b0;
            end
            @(posedge clk);
            #1;
            if (done_cyc >= 0) break;
        end
        i_req_count = MEM_COUNT_NONE;
        repeat (2) begin
            @(negedge clk);
            if (o_done !== 1'b0 || o_stall !== 1'b0) extra++;
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        int          dc;
        bit          sok;
        logic        f;
        logic [31:0] rd;
        int          ex;
        int          seen_done;

        vecs[0]  = '{1'b1, MEM_COUNT_WORD, 32'h0000_0010, 32'hdead_beef, 1'b0, 32'h0000_0000};
        vecs[1]  = '{1'b0, MEM_COUNT_WORD, 32'h0000_0010, 32'h0000_0000, 1'b0, 32'hdead_beef};
        vecs[2]  = '{1'b1, MEM_COUNT_BYTE, 32'h0000_0013, 32'h0000_00aa, 1'b0, 32'h0000_0000};
        vecs[3]  = '{1'b0, MEM_COUNT_WORD, 32'h0000_0010, 32'h0000_0000, 1'b0, 32'haaad_beef};
        vecs[4]  = '{1'b0, MEM_COUNT_HALF, 32'h0000_0012, 32'h0000_0000, 1'b0, 32'h0000_aaad};
        vecs[5]  = '{1'b0, MEM_COUNT_BYTE, 32'h0000_0011, 32'h0000_0000, 1'b0, 32'h0000_00be};
        vecs[6]  = '{1'b1, MEM_COUNT_HALF, 32'h0000_0011, 32'h0000_1234, 1'b1, 32'h0000_0000};
        vecs[7]  = '{1'b0, MEM_COUNT_WORD, 32'h0000_0010, 32'h0000_0000, 1'b0, 32'haaad_beef};
        vecs[8]  = '{1'b0, MEM_COUNT_WORD, 32'h0000_1000, 32'h0000_0000, 1'b1, 32'h0000_0000};
        vecs[9]  = '{1'b0, MEM_COUNT_HALF, 32'h0000_0010, 32'h0000_0000, 1'b0, 32'h0000_beef};
        vecs[10] = '{1'b1, MEM_COUNT_WORD, 32'h0000_0020, 32'h0102_0304, 1'b0, 32'h0000_0000};
        vecs[11] = '{1'b1, MEM_COUNT_HALF, 32'h0000_0022, 32'hcafe_5678, 1'b0, 32'h0000_0000};
        vecs[12] = '{1'b0, MEM_COUNT_WORD, 32'h0000_0020, 32'h0000_0000, 1'b0, 32'h5678_0304};
        vecs[13] = '{1'b0, MEM_COUNT_BYTE, 32'h0000_0023, 32'h0000_0000, 1'b0, 32'h0000_0056};
        vecs[14] = '{1'b0, MEM_COUNT_WORD, 32'h0000_0022, 32'h0000_0000, 1'b1, 32'h0000_0000};
        vecs[15] = '{1'b0, MEM_COUNT_BYTE, 32'h0000_1003, 32'h0000_0000, 1'b1, 32'h0000_0000};
        vecs[16] = '{1'b1, MEM_COUNT_WORD, 32'h0000_0ffc, 32'h0bad_f00d, 1'b0, 32'h0000_0000};
        vecs[17] = '{1'b0, MEM_COUNT_WORD, 32'h0000_0ffc, 32'h0000_0000, 1'b0, 32'h0bad_f00d};
        vecs[18] = '{1'b0, MEM_COUNT_BYTE, 32'h0000_0010, 32'h0000_0000, 1'b0, 32'h0000_00ef};

        // Reset and idle state.
        clr           = 1'b1;
        i_req_addr    = '0;
        i_req_wr_data = '0;
        i_req_wr_en   = 1'b0;
        i_req_count   = MEM_COUNT_NONE;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_stall", {31'b0, o_stall}, 32'd0);
        chk("reset_done", {31'b0, o_done}, 32'd0);
        chk("reset_fault", {31'b0, o_fault}, 32'd0);
        chk("reset_rd", o_rd_data, 32'd0);
        clr = 1'b0;
        @(posedge clk);
        #1;

        // Table-driven requests.
        for (int i = 0; i < NV; i++) begin
            run_req(vecs[i].wr, vecs[i].cnt, vecs[i].addr, vecs[i].data, dc, sok, f, rd, ex);
            chk($sformatf("v%0d_done_cycle", i), dc, LAT + 1);
            chk($sformatf("v%0d_stall_shape", i), {31'b0, sok}, 32'd1);
            chk($sformatf("v%0d_fault", i), {31'b0, f}, {31'b0, vecs[i].exp_fault});
            chk($sformatf("v%0d_rd", i), rd, vecs[i].exp_rd);
            chk($sformatf("v%0d_no_reaccept", i), ex, 0);
        end

        // Load result holds after completion while idle.
        run_req(1'b0, MEM_COUNT_WORD, 32'h0000_0010, 32'h0, dc, sok, f, rd, ex);
        repeat (3) @(posedge clk);
        #1;
        chk("rd_hold", o_rd_data, 32'haaad_beef);

        // Store aborted by reset in its first busy cycle.
        i_req_wr_en   = 1'b1;
        i_req_count   = MEM_COUNT_WORD;
        i_req_addr    = 32'h0000_0010;
        i_req_wr_data = 32'h1111_1111;
        @(negedge clk);
        chk("abort_stall_idle", {31'b0, o_stall}, 32'd1);
        @(posedge clk);
        #2;
        chk("abort_stall_busy", {31'b0, o_stall}, 32'd1);
        clr         = 1'b1;
        i_req_count = MEM_COUNT_NONE;
        #1;
        chk("abort_stall_drop", {31'b0, o_stall}, 32'd0);
        chk("abort_rd_cleared", o_rd_data, 32'd0);
        seen_done = 0;
        repeat (2) begin
            @(negedge clk);
            if (o_done !== 1'b0) seen_done++;
        end
        clr = 1'b0;
        repeat (3) begin
            @(negedge clk);
            if (o_done !== 1'b0 || o_stall !== 1'b0) seen_done++;
        end
        chk("abort_no_done", seen_done, 0);
        @(posedge clk);
        #1;
        run_req(1'b0, MEM_COUNT_WORD, 32'h0000_0010, 32'h0, dc, sok, f, rd, ex);
        chk("abort_ram_kept", rd, 32'haaad_beef);
        chk("abort_reload_cycle", dc, LAT + 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
